// File: rtl/cpu_stack_writeback_pkg.sv
// Shared constants and types for the stage-3 stack writeback block:
// push-selector codes, value tags, instruction size and FSM states.
package cpu_stack_writeback_pkg;

    // Push selector codes driven by the execute stage
    localparam logic [1:0] UC_PUSH_NONE = 2'd0;
    localparam logic [1:0] UC_PUSH_ALU  = 2'd1;
    localparam logic [1:0] UC_PUSH_COND = 2'd2;
    localparam logic [1:0] UC_PUSH_RET  = 2'd3;

    // Tags stored in bits [34:32] of every stack entry
    localparam logic [2:0] TAG_INT  = 3'b000;
    localparam logic [2:0] TAG_BOOL = 3'b001;
    localparam logic [2:0] TAG_RET  = 3'b010;

    // Every instruction is 48 bits, so the return address is pc + 6
    localparam logic [31:0] INSN_BYTES = 32'd6;

    localparam int ENTRY_W = 35;

    // RUN accepts operations; FILL_A/FILL_B refill the cached tops from RAM
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FILL_A = 2'd1,
        ST_FILL_B = 2'd2
    } st_state_t;

    // Build the tagged entry for a push selector (0 for "no push")
    function automatic logic [ENTRY_W-1:0] push_value(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic        cond,
        input logic [31:0] pc
    );
        logic [ENTRY_W-1:0] v;
        v = '0;
        case (sel)
            UC_PUSH_ALU:  v = {TAG_INT, alu};
            UC_PUSH_COND: v = {TAG_BOOL, 31'b0, cond};
            UC_PUSH_RET:  v = {TAG_RET, pc + INSN_BYTES};
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cpu_stack_ram.sv
// Operand stack storage: DEPTH x W, one write port, one synchronous read
// port with one cycle latency. Contents are not reset.
module cpu_stack_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int W      = 35
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Write port plus registered read; a same-address read returns the new
    // data so a refill issued in the cycle of a push sees the pushed entry.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_stack_writeback.sv
// Stage-3 stack writeback: applies pops then pushes to the operand stack,
// keeps the two newest entries cached for the stage-2 operand muxes and
// stalls while the cache is refilled from stack RAM after deep pops.
//
// Handshake: stall_3a is a registered hold. While it is high the block
// ignores its _3a inputs and upstream keeps them stable; an operation is
// consumed on every rising edge where the block is in RUN (stall_3a low).
module cpu_stack_writeback
    import cpu_stack_writeback_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              alu__cond_3a,
    input  logic [31:0]       alu__out_3a,
    input  logic [1:0]        c__to_push_3a,
    input  logic [47:0]       instruction_3a,
    input  logic [31:0]       pc_3a,
    input  logic [CNT_W-1:0]  st__to_pop_3a,
    output logic [34:0]       st__top_0_2a,
    output logic [34:0]       st__top_1_2a,
    output logic [CNT_W-1:0]  st__count,
    output logic              stall_3a,
    output logic              st__err_underflow,
    output logic              st__err_overflow
);

    // Registered state
    st_state_t           r_state;
    logic [CNT_W-1:0]    r_count;
    logic [34:0]         r_top0;
    logic [34:0]         r_top1;
    logic                r_stall;
    logic                r_err_uf;
    logic                r_err_of;
    logic                r_fill2;
    logic [ADDR_W-1:0]   r_fill_addr;

    // Next-state values
    st_state_t           w_state_nx;
    logic [CNT_W-1:0]    w_count_nx;
    logic [34:0]         w_top0_nx;
    logic [34:0]         w_top1_nx;
    logic                w_fill2_nx;
    logic [ADDR_W-1:0]   w_fill_addr_nx;
    logic                w_uf_set;
    logic                w_of_set;
    logic                w_need_fill1;
    logic                w_need_fill2;

    // Operation arithmetic
    logic [34:0]         w_push_val;
    logic                w_push_req;
    logic                w_underflow;
    logic [CNT_W-1:0]    w_pop;
    logic [CNT_W-1:0]    w_after_pop;
    logic                w_overflow;
    logic                w_push;
    logic [CNT_W-1:0]    w_n;
    logic                w_n_nonzero;
    logic                w_n_ge2;
    logic [ADDR_W-1:0]   w_n_m1;
    logic [ADDR_W-1:0]   w_n_m2;

    // RAM ports
    logic                w_we;
    logic [ADDR_W-1:0]   w_raddr;
    logic [34:0]         w_rdata;

    // The instruction word only travels with the pipeline for debug
    logic                w_unused_insn;
    assign w_unused_insn = ^instruction_3a;

    cpu_stack_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (35)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_n_m1),
        .i_wdata (w_push_val),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Pop-then-push arithmetic: clamp the pop, drop a push into a full stack
    always_comb begin
        w_push_val  = push_value(c__to_push_3a, alu__out_3a, alu__cond_3a, pc_3a);
        w_push_req  = (c__to_push_3a != UC_PUSH_NONE);
        w_underflow = (st__to_pop_3a > r_count);
        w_pop       = w_underflow ? r_count : st__to_pop_3a;
        w_after_pop = r_count - w_pop;
        w_overflow  = w_push_req && (w_after_pop == CNT_W'(DEPTH));
        w_push      = w_push_req && !w_overflow;
        w_n         = w_after_pop + {{(CNT_W-1){1'b0}}, w_push};
        w_n_nonzero = (w_n != '0);
        w_n_ge2     = (w_n >= CNT_W'(2));
        w_n_m1      = w_n[ADDR_W-1:0] - ADDR_W'(1);
        w_n_m2      = w_n[ADDR_W-1:0] - ADDR_W'(2);
    end

    // Next-state, cache update and RAM port control
    always_comb begin
        w_state_nx     = r_state;
        w_count_nx     = r_count;
        w_top0_nx      = r_top0;
        w_top1_nx      = r_top1;
        w_fill2_nx     = r_fill2;
        w_fill_addr_nx = r_fill_addr;
        w_uf_set       = 1'b0;
        w_of_set       = 1'b0;
        w_we           = 1'b0;
        w_raddr        = '0;
        w_need_fill1   = 1'b0;
        w_need_fill2   = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_count_nx = w_n;
                w_uf_set   = w_underflow;
                w_of_set   = w_overflow;
                w_we       = w_push;

                if (w_pop == '0) begin
                    if (w_push) begin
                        w_top1_nx = r_top0;
                        w_top0_nx = w_push_val;
                    end
                end else if (w_pop == CNT_W'(1)) begin
                    if (w_push) begin
                        w_top0_nx = w_push_val;
                    end else begin
                        w_top0_nx    = w_n_nonzero ? r_top1 : '0;
                        w_need_fill1 = 1'b1;
                    end
                end else if ((w_pop == CNT_W'(2)) && w_push) begin
                    w_top0_nx    = w_push_val;
                    w_need_fill1 = 1'b1;
                end else begin
                    w_need_fill2 = 1'b1;
                end

                // Only the second slot is stale: read RAM[N-2] if it exists
                if (w_need_fill1) begin
                    if (w_n_ge2) begin
                        w_raddr    = w_n_m2;
                        w_fill2_nx = 1'b0;
                        w_state_nx = ST_FILL_A;
                    end else begin
                        w_top1_nx  = '0;
                    end
                end

                // Both slots stale: read those that exist, lower one first
                if (w_need_fill2) begin
                    if (w_n_ge2) begin
                        w_raddr        = w_n_m2;
                        w_fill2_nx     = 1'b1;
                        w_fill_addr_nx = w_n_m1;
                        w_state_nx     = ST_FILL_A;
                    end else if (w_n_nonzero) begin
                        w_raddr    = '0;
                        w_top1_nx  = '0;
                        w_state_nx = ST_FILL_B;
                    end else begin
                        w_top0_nx  = '0;
                        w_top1_nx  = '0;
                    end
                end
            end

            ST_FILL_A: begin
                w_top1_nx = w_rdata;
                if (r_fill2) begin
                    w_raddr    = r_fill_addr;
                    w_state_nx = ST_FILL_B;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end

            ST_FILL_B: begin
                w_top0_nx  = w_rdata;
                w_state_nx = ST_RUN;
            end

            default: begin
                w_state_nx = ST_RUN;
            end
        endcase
    end

    // State register; stall is registered from the next state
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_RUN;
            r_count     <= '0;
            r_top0      <= '0;
            r_top1      <= '0;
            r_stall     <= 1'b0;
            r_err_uf    <= 1'b0;
            r_err_of    <= 1'b0;
            r_fill2     <= 1'b0;
            r_fill_addr <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_top0      <= w_top0_nx;
            r_top1      <= w_top1_nx;
            r_stall     <= (w_state_nx != ST_RUN);
            r_err_uf    <= r_err_uf | w_uf_set;
            r_err_of    <= r_err_of | w_of_set;
            r_fill2     <= w_fill2_nx;
            r_fill_addr <= w_fill_addr_nx;
        end
    end

    assign st__top_0_2a      = r_top0;
    assign st__top_1_2a      = r_top1;
    assign st__count         = r_count;
    assign stall_3a          = r_stall;
    assign st__err_underflow = r_err_uf;
    assign st__err_overflow  = r_err_of;

endmodule

// File: tb/tb_cpu_stack_writeback.sv
// Bench for cpu_stack_writeback: directed operations against a queue-based
// stack model, with literal expectations pinning key results.
module tb_cpu_stack_writeback;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        alu__cond_3a;
  logic [31:0] alu__out_3a;
  logic [1:0]  c__to_push_3a;
  logic [47:0] instruction_3a;
  logic [31:0] pc_3a;
  logic [10:0] st__to_pop_3a;
  logic [34:0] st__top_0_2a;
  logic [34:0] st__top_1_2a;
  logic [10:0] st__count;
  logic        stall_3a;
  logic        st__err_underflow;
  logic        st__err_overflow;

  cpu_stack_writeback dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .alu__cond_3a      (alu__cond_3a),
    .alu__out_3a       (alu__out_3a),
    .c__to_push_3a     (c__to_push_3a),
    .instruction_3a    (instruction_3a),
    .pc_3a             (pc_3a),
    .st__to_pop_3a     (st__to_pop_3a),
    .st__top_0_2a      (st__top_0_2a),
    .st__top_1_2a      (st__top_1_2a),
    .st__count         (st__count),
    .stall_3a          (stall_3a),
    .st__err_underflow (st__err_underflow),
    .st__err_overflow  (st__err_overflow)
  );

  // ---------------- scoreboard / model ----------------
  logic [34:0] exp_q[$];   // model stack, newest entry at the back
  logic        m_uf;
  logic        m_of;
  logic        chk_en;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] m_value(input int sel, input logic [31:0] alu,
                                          input logic cond, input logic [31:0] pc);
    case (sel)
      1:       return {3'b000, alu};
      2:       return {3'b001, 31'b0, cond};
      3:       return {3'b010, pc + 32'd6};
      default: return 35'h0;
    endcase
  endfunction

  function automatic logic [34:0] m_top(input int k);
    if (exp_q.size() > k) return exp_q[exp_q.size() - 1 - k];
    return 35'h0;
  endfunction

  // Apply one accepted operation to the model and predict the stall length
  task automatic model_apply(input int pop, input int sel, input logic [31:0] alu,
                             input logic cond, input logic [31:0] pc, output int exp_stall);
    int p;
    int n;
    bit u;
    p = pop;
    if (p > exp_q.size()) begin
      m_uf = 1'b1;
      p = exp_q.size();
    end
    repeat (p) void'(exp_q.pop_back());
    u = (sel != 0);
    if (u && exp_q.size() == DEPTH) begin
      m_of = 1'b1;
      u = 1'b0;
    end
    if (u) exp_q.push_back(m_value(sel, alu, cond, pc));
    n = exp_q.size();
    if (p == 0 || (p == 1 && u)) exp_stall = 0;
    else if ((p == 1 && !u) || (p == 2 && u)) exp_stall = (n >= 2) ? 1 : 0;
    else exp_stall = (n >= 2) ? 2 : ((n == 1) ? 1 : 0);
  endtask

  // Compare process: every settled cycle, DUT outputs vs model
  always @(negedge clk) begin
    if (chk_en && rst_b && !stall_3a) begin
      chk("count", 64'(st__count), 64'(exp_q.size()));
      chk("top0", 64'(st__top_0_2a), 64'(m_top(0)));
      chk("top1", 64'(st__top_1_2a), 64'(m_top(1)));
      chk("err_underflow", 64'(st__err_underflow), 64'(m_uf));
      chk("err_overflow", 64'(st__err_overflow), 64'(m_of));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    st__to_pop_3a  = 11'd0;
    c__to_push_3a  = 2'd0;
    alu__out_3a    = 32'h0;
    alu__cond_3a   = 1'b0;
    pc_3a          = 32'h0;
    instruction_3a = 48'h0;
  endtask

  task automatic op(input int pop, input int sel, input logic [31:0] alu,
                    input logic cond, input logic [31:0] pc, output int stall_len);
    int es;
    int n;
    @(negedge clk);
    st__to_pop_3a  = 11'(pop);
    c__to_push_3a  = 2'(sel);
    alu__out_3a    = alu;
    alu__cond_3a   = cond;
    pc_3a          = pc;
    instruction_3a = 48'($urandom);
    @(posedge clk);
    #1;
    idle_inputs();
    model_apply(pop, sel, alu, cond, pc, es);
    n = 0;
    @(negedge clk);
    while (stall_3a && n < 6) begin
      n++;
      @(negedge clk);
    end
    chk("stall_len", 64'(n), 64'(es));
    stall_len = n;
  endtask

  task automatic apply_reset();
    chk_en = 1'b0;
    rst_b  = 1'b0;
    exp_q.delete();
    m_uf = 1'b0;
    m_of = 1'b0;
    repeat (2) @(negedge clk);
    rst_b  = 1'b1;
    chk_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int sl;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    m_uf   = 1'b0;
    m_of   = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_count", 64'(st__count), 64'd0);
    chk("rst_top0", 64'(st__top_0_2a), 64'd0);
    chk("rst_top1", 64'(st__top_1_2a), 64'd0);
    chk("rst_stall", 64'(stall_3a), 64'd0);
    chk("rst_flags", 64'({st__err_underflow, st__err_overflow}), 64'd0);
    apply_reset();

    // three ALU pushes, no stall
    op(0, 1, 32'h11, 1'b0, 32'h0, sl); chk("push1_stall", 64'(sl), 64'd0);
    op(0, 1, 32'h22, 1'b0, 32'h0, sl); chk("push2_stall", 64'(sl), 64'd0);
    op(0, 1, 32'h33, 1'b0, 32'h0, sl); chk("push3_stall", 64'(sl), 64'd0);
    chk("lit_count3", 64'(st__count), 64'd3);
    chk("lit_top0_33", 64'(st__top_0_2a), 64'h0_0000_0033);
    chk("lit_top1_22", 64'(st__top_1_2a), 64'h0_0000_0022);

    // pop one: top1 refilled after a 1-cycle stall
    op(1, 0, 32'h0, 1'b0, 32'h0, sl);
    chk("pop1_stall", 64'(sl), 64'd1);
    chk("lit_pop1_top0", 64'(st__top_0_2a), 64'h22);
    chk("lit_pop1_top1", 64'(st__top_1_2a), 64'h11);
    chk("lit_pop1_count", 64'(st__count), 64'd2);

    // empty, push 1..5, pop 3: 2-cycle refill
    op(2, 0, 32'h0, 1'b0, 32'h0, sl);
    for (int i = 1; i <= 5; i++) op(0, 1, 32'(i), 1'b0, 32'h0, sl);
    op(3, 0, 32'h0, 1'b0, 32'h0, sl);
    chk("pop3_stall", 64'(sl), 64'd2);
    chk("lit_pop3_top0", 64'(st__top_0_2a), 64'h2);
    chk("lit_pop3_top1", 64'(st__top_1_2a), 64'h1);
    chk("lit_pop3_count", 64'(st__count), 64'd2);

    // return address and condition pushes
    op(0, 3, 32'h0, 1'b0, 32'h100, sl);
    chk("lit_ret", 64'(st__top_0_2a), 64'h2_0000_0106);
    op(0, 3, 32'h0, 1'b0, 32'hFFFF_FFFC, sl);
    chk("lit_ret_wrap", 64'(st__top_0_2a), 64'h2_0000_0002);
    op(0, 2, 32'hDEAD_BEEF, 1'b1, 32'h0, sl);
    chk("lit_bool", 64'(st__top_0_2a), 64'h1_0000_0001);
    chk("lit_bool_top1", 64'(st__top_1_2a), 64'h2_0000_0002);

    // underflow: count 1, pop 4
    op(5, 0, 32'h0, 1'b0, 32'h0, sl);
    op(0, 1, 32'h99, 1'b0, 32'h0, sl);
    op(4, 0, 32'h0, 1'b0, 32'h0, sl);
    chk("uf_stall", 64'(sl), 64'd0);
    chk("lit_uf", 64'(st__err_underflow), 64'd1);
    chk("lit_uf_count", 64'(st__count), 64'd0);
    chk("lit_uf_tops", 64'({st__top_0_2a, st__top_1_2a}), 64'd0);
    op(0, 1, 32'h5, 1'b0, 32'h0, sl);
    chk("lit_uf_sticky", 64'(st__err_underflow), 64'd1);
    op(1, 0, 32'h0, 1'b0, 32'h0, sl);

    // mixed pop+push cases
    op(0, 1, 32'hA1, 1'b0, 32'h0, sl);
    op(0, 1, 32'hA2, 1'b0, 32'h0, sl);
    op(0, 1, 32'hA3, 1'b0, 32'h0, sl);
    op(0, 1, 32'hA4, 1'b0, 32'h0, sl);
    op(1, 1, 32'hB1, 1'b0, 32'h0, sl);
    chk("p1u1_stall", 64'(sl), 64'd0);
    chk("lit_p1u1_top1", 64'(st__top_1_2a), 64'hA3);
    op(2, 1, 32'hC1, 1'b0, 32'h0, sl);
    chk("p2u1_stall", 64'(sl), 64'd1);
    chk("lit_p2u1_top1", 64'(st__top_1_2a), 64'hA2);
    op(3, 1, 32'hD1, 1'b0, 32'h0, sl);
    chk("p3u1_n1_stall", 64'(sl), 64'd1);
    chk("lit_p3u1_top0", 64'(st__top_0_2a), 64'hD1);
    chk("lit_p3u1_top1", 64'(st__top_1_2a), 64'h0);
    op(0, 1, 32'hE1, 1'b0, 32'h0, sl);
    op(0, 1, 32'hE2, 1'b0, 32'h0, sl);
    op(0, 1, 32'hE3, 1'b0, 32'h0, sl);
    op(3, 1, 32'hF1, 1'b0, 32'h0, sl);
    chk("p3u1_n2_stall", 64'(sl), 64'd2);
    chk("lit_p3u1_n2_top0", 64'(st__top_0_2a), 64'hF1);
    chk("lit_p3u1_n2_top1", 64'(st__top_1_2a), 64'hD1);

    // fill to DEPTH, then one more push overflows
    while (exp_q.size() < DEPTH) op(0, 1, $urandom, 1'b0, 32'h0, sl);
    chk("lit_full_count", 64'(st__count), 64'd1024);
    chk("lit_of_before", 64'(st__err_overflow), 64'd0);
    op(0, 1, 32'h1234_5678, 1'b0, 32'h0, sl);
    chk("lit_of", 64'(st__err_overflow), 64'd1);
    chk("lit_of_count", 64'(st__count), 64'd1024);
    op(1, 1, 32'hCAFE, 1'b0, 32'h0, sl);
    chk("lit_full_replace", 64'(st__top_0_2a), 64'hCAFE);

    // asynchronous reset in FILL_A of a 3-entry pop
    @(negedge clk);
    st__to_pop_3a = 11'd3;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("fill_a_stall", 64'(stall_3a), 64'd1);
    chk_en = 1'b0;
    rst_b  = 1'b0;
    exp_q.delete();
    m_uf = 1'b0;
    m_of = 1'b0;
    #1;
    chk("rstmid_stall", 64'(stall_3a), 64'd0);
    chk("rstmid_count", 64'(st__count), 64'd0);
    chk("rstmid_tops", 64'({st__top_0_2a, st__top_1_2a}), 64'd0);
    chk("rstmid_flags", 64'({st__err_underflow, st__err_overflow}), 64'd0);
    @(negedge clk);
    rst_b  = 1'b1;
    chk_en = 1'b1;
    op(0, 1, 32'h77, 1'b0, 32'h0, sl);
    chk("post_rst_stall", 64'(sl), 64'd0);
    chk("lit_post_rst_top0", 64'(st__top_0_2a), 64'h77);
    chk("lit_post_rst_count", 64'(st__count), 64'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
